mprj_io_stim_seq: RTL and testbench
===================================

// Module: mprj_io_stim_seq
// PURPOSE
//  Wishbone-programmable sequencer in the user project area that drives the test
//  pattern lanes on user IO: checkbits on io_out[31:16] and status on io_out[35:32].
//  Firmware loads a table of {status, checkbits, hold} entries and starts the run.
//  The block steps through the table with cycle-exact hold times, once or looping.
//  Used by DV benches that wait on mprj_io patterns.
// PARAMETERS
//  ADDR_BASE  32'h3000_0000  slave base; decode matches wbs_adr_i[31:8] == ADDR_BASE[31:8]
//  DEPTH      8              entries in table (power of 2, 2..16)
//  HOLD_W     12             hold-count width (fixed by entry layout)
// PORTS
//  wb_clk_i     in   1   clock
//  wb_rst_i     in   1   synchronous reset, active-high
//  wbs_stb_i    in   1   Wishbone strobe
//  wbs_cyc_i    in   1   Wishbone cycle
//  wbs_we_i     in   1   write enable
//  wbs_sel_i    in   4   byte selects (writes honour sel; reads ignore it)
//  wbs_adr_i    in   32  byte address
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   acknowledge
//  wbs_dat_o    out  32  read data
//  io_out       out  38  user IO outputs
//  io_oeb       out  38  user IO output-enable, active-low
//  irq_o        out  1   completion interrupt
// BEHAVIOUR
//  Reset: wbs_ack_o=0, wbs_dat_o=0, io_out=0, io_oeb=all 1, irq_o=0, regs=0, state IDLE.
//  Wishbone: access accepted on a cycle with stb&cyc&decode&!ack; ack=1 next cycle for 1 cycle.
//   Unmapped offsets: read 0, writes dropped, still acked.
//  Map (offset): 0x00 CTRL  [0]START(W, self-clr) [1]LOOP [2]ABORT(W, self-clr) [3]OE [4]IRQ_EN
//   0x04 STAT [0]BUSY [1]DONE(W1C) [7:4]IDX.  0x08 LEN [4:0]; writes above DEPTH clamp to DEPTH.
//   0x20+4*i ENTRY i: [15:0]checkbits [19:16]status [31:20]hold.
//  io_oeb[35:16] = ~{20{OE}}; all other io_oeb bits 1, all other io_out bits 0.
//  FSM IDLE/RUN. Everything below takes effect on the clock edge that accepts the CTRL write.
//   IDLE + START, LEN!=0: RUN; IDX=0; io_out[35:16]={status0, check0}; cnt=hold0; DONE=0.
//   IDLE + START, LEN==0: ignored.
//   RUN, cnt!=0: cnt decrements.
//   RUN, cnt==0: load the next entry the same edge.
//    After the last entry (IDX==LEN-1): LOOP=1 wraps to IDX 0.
//    LOOP=0 goes to IDLE, sets DONE=1 and holds the last pattern.
//   Entry k is therefore driven for exactly hold_k+1 cycles (hold=0 -> 1 cycle).
//  ABORT (any state): IDLE; io_out[35:16]=0; DONE unchanged.
//   START and ABORT in the same write: ABORT wins.
//  START while RUN: ignored.
//  ENTRY write during RUN: allowed; used the next time that entry loads, not the current hold.
//  LEN write during RUN: ignored.
//  START also clears DONE. A DONE W1C in the same cycle the run completes: set wins.
//  wb_rst_i mid-run: immediate return to reset state; table contents are cleared.
// CONFIGURATION
//  MPRJ_STIM_SEQ_IRQ_EN defined: irq_o = DONE & IRQ_EN (registered; clears on DONE W1C or START).
//  MPRJ_STIM_SEQ_IRQ_EN undefined: irq_o tied 0; CTRL[4] is not stored and reads 0.
// TESTING
//  Reset held 5 cycles -> io_oeb=38'h3F_FFFF_FFFF, io_out=0, STAT=0, ack=0.
//  Single run: E0={a,AB40,3}, E1={5,0840,0}, E2={5,AB51,9}, LEN=3, CTRL=0x9
//   -> [31:16]=AB40 for 4 cycles, then 0840 for 1 cycle, then AB51 for 10 cycles.
//   -> Then DONE=1, BUSY=0, [35:16] held at 5_AB51.
//  Loop: E0={a,AB40,1}, E1={5,0A00,1}, LEN=2, CTRL=0xB
//   -> Pattern alternates with period 4 cycles.
//   -> CTRL=0x4: [35:16]=0 on the accept edge, DONE=0.
//  Boundaries: LEN=0 + START -> stays IDLE. Write LEN=12 -> reads 8.
//   START during RUN -> IDX unaffected. CTRL=0x5 (START+ABORT) -> IDLE.
//  OE=0 run -> io_out still sequences, io_oeb stays all 1.
//   Unmapped read (offset 0x10) -> data 0, ack after 1 cycle.
//  With MPRJ_STIM_SEQ_IRQ_EN, IRQ_EN=1: irq_o rises with DONE.
//   STAT write 0x2 -> irq_o=0 next cycle. Without the macro: irq_o stays 0.

Source files
------------

// File: rtl/mprj_io_stim_seq.sv
// Wishbone-programmable pattern sequencer driving checkbits/status lanes on mprj_io[35:16].
// Optional completion interrupt enabled by defining MPRJ_STIM_SEQ_IRQ_EN.
module mprj_io_stim_seq #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          DEPTH     = 8,
  parameter int          HOLD_W    = 12
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [37:0] io_out,
  output logic [37:0] io_oeb,
  output logic        irq_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              loop_q, loop_d;
  logic              oe_q, oe_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              irq_q, irq_d;
  logic [3:0]        idx_q, idx_d;
  logic [4:0]        len_q, len_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [19:0]       pat_q, pat_d;
  logic [31:0]       table_q [DEPTH];
  logic [31:0]       table_d [DEPTH];

  logic          dec_s, acc_s, wr_s, ctrl_wr_s, start_s, abort_s, ent_hit_s, last_s;
  logic [5:0]    word_s, ent_off_s;
  logic [IW-1:0] ent_idx_s;
  logic [3:0]    nxt_idx_s;
  logic [31:0]   rdata_s;
  logic          unused_s;

  assign dec_s     = (wbs_adr_i[31:8] == ADDR_BASE[31:8]);
  assign acc_s     = wbs_stb_i & wbs_cyc_i & dec_s & ~ack_q;
  assign wr_s      = acc_s & wbs_we_i;
  assign word_s    = wbs_adr_i[7:2];
  assign ent_off_s = word_s - 6'd8;
  assign ent_hit_s = (word_s >= 6'd8) && (word_s < 6'(8 + DEPTH));
  assign ent_idx_s = ent_off_s[IW-1:0];
  assign ctrl_wr_s = wr_s & (word_s == 6'd0) & wbs_sel_i[0];
  // ABORT takes priority, so a combined START+ABORT never counts as a start
  assign start_s   = ctrl_wr_s & wbs_dat_i[0] & ~wbs_dat_i[2];
  assign abort_s   = ctrl_wr_s & wbs_dat_i[2];
  assign last_s    = ({1'b0, idx_q} == (len_q - 5'd1));
  assign nxt_idx_s = last_s ? 4'd0 : (idx_q + 4'd1);
  assign unused_s  = ^{wbs_adr_i[1:0], ent_off_s};

  // register read mux
  always_comb begin
    rdata_s = 32'd0;
    if (ent_hit_s) begin
      rdata_s = table_q[ent_idx_s];
    end else begin
      case (word_s)
        6'd0:    rdata_s = {27'd0, irq_en_q, oe_q, 1'b0, loop_q, 1'b0};
        6'd1:    rdata_s = {24'd0, idx_q, 2'd0, done_q, (state_q == RUN)};
        6'd2:    rdata_s = {27'd0, len_q};
        default: rdata_s = 32'd0;
      endcase
    end
  end

  // bus writes, sequencer next state and interrupt
  always_comb begin
    state_d  = state_q;
    ack_d    = acc_s;
    dat_d    = (acc_s && !wbs_we_i) ? rdata_s : 32'd0;
    loop_d   = loop_q;
    oe_d     = oe_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    idx_d    = idx_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    table_d  = table_q;

    if (wr_s && ent_hit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs_sel_i[b]) begin
          table_d[ent_idx_s][8*b +: 8] = wbs_dat_i[8*b +: 8];
        end else begin
          table_d[ent_idx_s][8*b +: 8] = table_q[ent_idx_s][8*b +: 8];
        end
      end
    end else if (wr_s && wbs_sel_i[0]) begin
      case (word_s)
        6'd0: begin
          loop_d   = wbs_dat_i[1];
          oe_d     = wbs_dat_i[3];
          irq_en_d = wbs_dat_i[4];
        end
        6'd1: done_d = wbs_dat_i[1] ? 1'b0 : done_q;
        6'd2: begin
          if (state_q == IDLE) begin
            len_d = (wbs_dat_i[4:0] > DEPTH_L) ? DEPTH_L : wbs_dat_i[4:0];
          end else begin
            len_d = len_q;
          end
        end
        default: len_d = len_q;
      endcase
    end else begin
      len_d = len_q;
    end

    // completion set comes after the W1C so it wins in the same cycle
    case (state_q)
      IDLE: begin
        if (start_s && (len_q != 5'd0)) begin
          state_d = RUN;
          idx_d   = 4'd0;
          pat_d   = table_q[0][19:0];
          cnt_d   = table_q[0][31:20];
          done_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q != {HOLD_W{1'b0}}) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (last_s && !loop_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = nxt_idx_s;
          pat_d = table_q[nxt_idx_s[IW-1:0]][19:0];
          cnt_d = table_q[nxt_idx_s[IW-1:0]][31:20];
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_s) begin
      state_d = IDLE;
      pat_d   = 20'd0;
    end else begin
      pat_d = pat_d;
    end

`ifdef MPRJ_STIM_SEQ_IRQ_EN
    irq_d = done_d & irq_en_d;
`else
    irq_en_d = 1'b0;
    irq_d    = 1'b0;
`endif
  end

  // state registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      dat_q    <= 32'd0;
      loop_q   <= 1'b0;
      oe_q     <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      idx_q    <= 4'd0;
      len_q    <= 5'd0;
      cnt_q    <= {HOLD_W{1'b0}};
      pat_q    <= 20'd0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      loop_q   <= loop_d;
      oe_q     <= oe_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      table_q  <= table_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = {2'b00, pat_q, 16'h0000};
  assign io_oeb    = {2'b11, {20{~oe_q}}, 16'hFFFF};
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_mprj_io_stim_seq.sv
// Directed self-checking bench for mprj_io_stim_seq (define MPRJ_STIM_SEQ_IRQ_EN to check the IRQ build).
module tb_mprj_io_stim_seq;

  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef MPRJ_STIM_SEQ_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, dati = 32'd0;
  logic        ack;
  logic [31:0] dato;
  logic [37:0] io_out, io_oeb;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] rv;
  int          lat;

  always #5 clk = ~clk;

  mprj_io_stim_seq dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dati),
    .wbs_ack_o(ack),
    .wbs_dat_o(dato),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq_o    (irq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one Wishbone access; returns at the falling edge where ack is seen
  task automatic wb(input logic w, input logic [7:0] off, input logic [31:0] d,
                    output logic [31:0] r, output int n);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; sel = 4'hF;
    adr = BASE | {24'd0, off}; dati = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack !== 1'b1 && n < 8);
    r = dato;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (ack !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL wb_ack_timeout off=%0h observed=%b expected=1", off, ack);
    end
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] r;
    int n;
    wb(1'b1, off, d, r, n);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    int n;
    wb(1'b0, off, 32'd0, r, n);
  endtask

  initial begin
    // reset
    repeat (5) @(negedge clk);
    chk("rst_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    chk("rst_out", io_out, 38'd0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_irq", irq, 1'b0);
    rst = 1'b0;
    rd(8'h04, rv); chk("rst_stat", rv, 32'h0);

    // single run
    wr(8'h20, 32'h003A_AB40);
    wr(8'h24, 32'h0005_0840);
    wr(8'h28, 32'h0095_AB51);
    rd(8'h28, rv); chk("entry2_rb", rv, 32'h0095_AB51);
    wr(8'h08, 32'd3);
    wr(8'h00, 32'h9);
    chk("run1_oeb", io_oeb, 38'h30_0000_FFFF);
    for (int i = 0; i < 4; i++) begin
      chk("run1_e0", io_out[35:16], 20'hAAB40);
      @(negedge clk);
    end
    chk("run1_e1", io_out[35:16], 20'h50840);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("run1_e2", io_out[35:16], 20'h5AB51);
      @(negedge clk);
    end
    chk("run1_hold", io_out, {2'b00, 20'h5AB51, 16'h0000});
    rd(8'h04, rv); chk("run1_stat", rv, 32'h22);

    // looping run, then abort
    wr(8'h20, 32'h001A_AB40);
    wr(8'h24, 32'h0015_0A00);
    wr(8'h08, 32'd2);
    wr(8'h00, 32'hB);
    for (int i = 0; i < 8; i++) begin
      chk("loop_pat", io_out[35:16], (((i / 2) % 2) == 0) ? 20'hAAB40 : 20'h50A00);
      @(negedge clk);
    end
    rd(8'h04, rv); chk("loop_stat", rv[1:0], 2'b01);
    wr(8'h00, 32'h4);
    chk("abort_out", io_out, 38'd0);
    rd(8'h04, rv); chk("abort_stat", rv[1:0], 2'b00);

    // LEN boundaries
    wr(8'h08, 32'd0);
    wr(8'h00, 32'h1);
    rd(8'h04, rv); chk("len0_idle", rv[1:0], 2'b00);
    chk("len0_out", io_out, 38'd0);
    wr(8'h08, 32'd12);
    rd(8'h08, rv); chk("len_clamp", rv, 32'd8);

    // START during RUN, ENTRY write during RUN, START+ABORT
    wr(8'h20, 32'h0011_2345);
    wr(8'h24, 32'hFFF2_6789);
    wr(8'h08, 32'd2);
    wr(8'h00, 32'h1);
    repeat (3) @(negedge clk);
    rd(8'h04, rv); chk("run_idx1", rv, 32'h11);
    wr(8'h00, 32'h1);
    chk("restart_pat", io_out[35:16], 20'h26789);
    rd(8'h04, rv); chk("restart_idx", rv, 32'h11);
    wr(8'h08, 32'd1);
    rd(8'h08, rv); chk("len_locked", rv, 32'd2);
    wr(8'h24, 32'h00A7_7777);
    chk("entwr_pat", io_out[35:16], 20'h26789);
    wr(8'h00, 32'h5);
    chk("startabort_out", io_out, 38'd0);
    rd(8'h04, rv); chk("startabort_stat", rv[1:0], 2'b00);

    // OE=0 run and DONE W1C
    wr(8'h20, 32'h0023_1234);
    wr(8'h08, 32'd1);
    wr(8'h00, 32'h1);
    chk("noe_out", io_out, {2'b00, 20'h31234, 16'h0000});
    chk("noe_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    repeat (3) @(negedge clk);
    rd(8'h04, rv); chk("noe_done", rv, 32'h02);
    wr(8'h04, 32'h2);
    rd(8'h04, rv); chk("w1c_stat", rv, 32'h0);

    // unmapped offset
    wr(8'h10, 32'hFFFF_FFFF);
    wb(1'b0, 8'h10, 32'd0, rv, lat);
    chk("unmap_data", rv, 32'h0);
    chk("unmap_lat", lat, 1);

    // interrupt
    wr(8'h00, 32'h11);
    chk("irq_pre", irq, 1'b0);
    repeat (3) @(negedge clk);
    chk("irq_done", irq, IRQ_BUILD);
    rd(8'h00, rv); chk("ctrl_irqen", rv, IRQ_BUILD ? 32'h10 : 32'h0);
    wr(8'h04, 32'h2);
    chk("irq_w1c", irq, 1'b0);

    // reset mid-run clears table
    wr(8'h20, 32'hFFF1_ABCD);
    wr(8'h00, 32'h9);
    chk("rst_run_pat", io_out[35:16], 20'h1ABCD);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run_out", io_out, 38'd0);
    chk("rst_run_oeb", io_oeb, 38'h3F_FFFF_FFFF);
    rd(8'h20, rv); chk("rst_tbl", rv, 32'h0);
    rd(8'h08, rv); chk("rst_len", rv, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
